// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-sequence game: state codes and a one-hot helper.
package jogo_pkg;

    // State codes are fixed because the board wrapper decodes db_estado for its displays.
    typedef enum logic [3:0] {
        ST_INICIAL     = 4'h0,
        ST_PREPARA     = 4'h1,
        ST_ESPERA      = 4'h2,
        ST_REGISTRA    = 4'h3,
        ST_COMPARA     = 4'h4,
        ST_PROX_JOGADA = 4'h5,
        ST_PROX_RODADA = 4'h6,
        ST_ESPERA_NOVA = 4'h7,
        ST_ESCREVE     = 4'h8,
        ST_FIM_GANHOU  = 4'hA,
        ST_FIM_TIMEOUT = 4'hD,
        ST_FIM_ERRO    = 4'hE
    } estado_t;

    // True when exactly one bit is set; callers zero-extend narrower vectors.
    function automatic logic is_onehot(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/detector_jogada.sv
// Button front end: two register stages, rising-press detection and one-hot validity.
module detector_jogada
    import jogo_pkg::*;
#(
    parameter int N_BOTOES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] b_q,
    output logic                tem_jogada,
    output logic                valida
);

    logic [N_BOTOES-1:0] b_d;
    logic [N_BOTOES-1:0] b_qq;
    logic [N_BOTOES-1:0] b_qq_d;

    // Next values of the two-stage pipeline.
    always_comb begin
        b_d    = botoes;
        b_qq_d = b_q;
    end

    // Pipeline registers; reset clears both so no phantom press follows a reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            b_q  <= '0;
            b_qq <= '0;
        end else begin
            b_q  <= b_d;
            b_qq <= b_qq_d;
        end
    end

    // A press is the first cycle something is held after a cycle with nothing held.
    always_comb begin
        tem_jogada = (b_q != '0) && (b_qq == '0);
        valida     = is_onehot(32'(b_q));
    end

endmodule

// File: rtl/jogo_sequencias_param.sv
// Memory-sequence game: sequence memory, round/address/timeout counters and control FSM.
module jogo_sequencias_param
    import jogo_pkg::*;
#(
    parameter int N_BOTOES       = 4,
    parameter int PROF           = 16,
    parameter int AW             = $clog2(PROF),
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic                modo,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                carga_we,
    input  logic [AW-1:0]       carga_end,
    input  logic [N_BOTOES-1:0] carga_dado,
    output logic [N_BOTOES-1:0] leds,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                db_timeout,
    output logic [3:0]          db_estado,
    output logic [AW-1:0]       db_rodada,
    output logic [AW-1:0]       db_endereco
);

    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [AW-1:0] ULTIMA  = AW'(PROF - 1);

    estado_t             estado_q, estado_d;
    logic [AW-1:0]       rodada_q, rodada_d;
    logic [AW-1:0]       endereco_q, endereco_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [N_BOTOES-1:0] jogada_q, jogada_d;
    logic                modo_q, modo_d;
    logic                jogar_q, jogar_d;

    logic [N_BOTOES-1:0] b_q;
    logic                tem_jogada;
    logic                valida;
    logic                jogar_subida;
    logic                aceita_carga;

    logic [N_BOTOES-1:0] mem [PROF];
    logic [N_BOTOES-1:0] mem_rdata;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [N_BOTOES-1:0] mem_wdata;

    detector_jogada #(.N_BOTOES(N_BOTOES)) u_detector (
        .clock      (clock),
        .reset      (reset),
        .botoes     (botoes),
        .b_q        (b_q),
        .tem_jogada (tem_jogada),
        .valida     (valida)
    );

    // jogar is registered once so that only its rising edge starts a game.
    always_comb begin
        jogar_d      = jogar;
        jogar_subida = jogar && !jogar_q;
        aceita_carga = (estado_q == ST_INICIAL)    || (estado_q == ST_FIM_GANHOU) ||
                       (estado_q == ST_FIM_ERRO)   || (estado_q == ST_FIM_TIMEOUT);
    end

    // Control FSM: next state and counter updates.
    always_comb begin
        estado_d   = estado_q;
        rodada_d   = rodada_q;
        endereco_d = endereco_q;
        tmo_d      = tmo_q;
        jogada_d   = jogada_q;
        modo_d     = modo_q;
        case (estado_q)
            ST_INICIAL: begin
                if (jogar_subida) estado_d = ST_PREPARA;
            end
            ST_PREPARA: begin
                rodada_d   = '0;
                endereco_d = '0;
                tmo_d      = '0;
                modo_d     = modo;
                estado_d   = ST_ESPERA;
            end
            ST_ESPERA: begin
                tmo_d = tmo_q + 1'b1;
                if (tem_jogada)            estado_d = ST_REGISTRA;
                else if (tmo_q == TMO_MAX) estado_d = ST_FIM_TIMEOUT;
            end
            ST_REGISTRA: begin
                jogada_d = b_q;
                tmo_d    = '0;
                estado_d = ST_COMPARA;
            end
            ST_COMPARA: begin
                // An invalid (not one-hot) jogada never counts as a match.
                if ((jogada_q != mem_rdata) || !is_onehot(32'(jogada_q)))
                    estado_d = ST_FIM_ERRO;
                else if (endereco_q != rodada_q)
                    estado_d = ST_PROX_JOGADA;
                else if (rodada_q == ULTIMA)
                    estado_d = ST_FIM_GANHOU;
                else if (modo_q)
                    estado_d = ST_ESPERA_NOVA;
                else
                    estado_d = ST_PROX_RODADA;
            end
            ST_PROX_JOGADA: begin
                if (endereco_q != rodada_q) endereco_d = endereco_q + 1'b1;
                estado_d = ST_ESPERA;
            end
            ST_PROX_RODADA: begin
                if (rodada_q != ULTIMA) rodada_d = rodada_q + 1'b1;
                endereco_d = '0;
                tmo_d      = '0;
                estado_d   = ST_ESPERA;
            end
            ST_ESPERA_NOVA: begin
                tmo_d = tmo_q + 1'b1;
                if (tem_jogada)            estado_d = valida ? ST_ESCREVE : ST_FIM_ERRO;
                else if (tmo_q == TMO_MAX) estado_d = ST_FIM_TIMEOUT;
            end
            ST_ESCREVE: begin
                estado_d = ST_PROX_RODADA;
            end
            ST_FIM_GANHOU, ST_FIM_ERRO, ST_FIM_TIMEOUT: begin
                if (jogar_subida) estado_d = ST_PREPARA;
            end
            default: estado_d = ST_INICIAL;
        endcase
    end

    // State and counter registers; memory is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= ST_INICIAL;
            rodada_q   <= '0;
            endereco_q <= '0;
            tmo_q      <= '0;
            jogada_q   <= '0;
            modo_q     <= 1'b0;
            jogar_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            rodada_q   <= rodada_d;
            endereco_q <= endereco_d;
            tmo_q      <= tmo_d;
            jogada_q   <= jogada_d;
            modo_q     <= modo_d;
            jogar_q    <= jogar_d;
        end
    end

    // Memory write port: the game's own append in ESCREVE, else an accepted preload.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = carga_end;
        mem_wdata = carga_dado;
        if (estado_q == ST_ESCREVE) begin
            mem_we    = 1'b1;
            mem_waddr = rodada_q + 1'b1;
            mem_wdata = b_q;
        end else if (carga_we && aceita_carga) begin
            mem_we = 1'b1;
        end
    end

    // Synchronous write; read is combinational at the address counter.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign mem_rdata = mem[endereco_q];

    // Status outputs decoded from the current state.
    always_comb begin
        leds = '0;
        case (estado_q)
            ST_REGISTRA:                                leds = b_q;
            ST_COMPARA, ST_PROX_JOGADA, ST_PROX_RODADA: leds = jogada_q;
            default:                                    leds = '0;
        endcase
        ganhou      = (estado_q == ST_FIM_GANHOU);
        db_timeout  = (estado_q == ST_FIM_TIMEOUT);
        perdeu      = (estado_q == ST_FIM_ERRO) || (estado_q == ST_FIM_TIMEOUT);
        pronto      = ganhou || perdeu;
        db_estado   = estado_q;
        db_rodada   = rodada_q;
        db_endereco = endereco_q;
    end

endmodule

// File: tb/tb_jogo_sequencias_param.sv
// Self-checking bench for jogo_sequencias_param with a small board (4 buttons, depth 4).
module tb_jogo_sequencias_param;

    localparam int NB  = 4;
    localparam int PF  = 4;
    localparam int AWB = 2;
    localparam int TMO = 10;

    localparam logic [3:0] S_INICIAL = 4'h0;
    localparam logic [3:0] S_ESPERA  = 4'h2;
    localparam logic [3:0] S_REGIS   = 4'h3;
    localparam logic [3:0] S_COMPARA = 4'h4;
    localparam logic [3:0] S_PROXJ   = 4'h5;
    localparam logic [3:0] S_GANHOU  = 4'hA;
    localparam logic [3:0] S_TMO     = 4'hD;
    localparam logic [3:0] S_ERRO    = 4'hE;

    logic           clock = 1'b0;
    logic           reset;
    logic           jogar;
    logic           modo;
    logic [NB-1:0]  botoes;
    logic           carga_we;
    logic [AWB-1:0] carga_end;
    logic [NB-1:0]  carga_dado;
    logic [NB-1:0]  leds;
    logic           pronto, ganhou, perdeu, db_timeout;
    logic [3:0]     db_estado;
    logic [AWB-1:0] db_rodada, db_endereco;

    int vectors     = 0;
    int miscompares = 0;
    logic [11:0] exp_q[$];

    jogo_sequencias_param #(
        .N_BOTOES(NB), .PROF(PF), .AW(AWB), .TIMEOUT_CICLOS(TMO)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .modo(modo), .botoes(botoes),
        .carga_we(carga_we), .carga_end(carga_end), .carga_dado(carga_dado),
        .leds(leds), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
        .db_timeout(db_timeout), .db_estado(db_estado), .db_rodada(db_rodada),
        .db_endereco(db_endereco)
    );

    // Clock and watchdog.
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [11:0] pack(input logic p, input logic g, input logic e,
                                         input logic t, input logic [3:0] s,
                                         input logic [1:0] r, input logic [1:0] a);
        return {p, g, e, t, s, r, a};
    endfunction

    function automatic logic [11:0] observed();
        return pack(pronto, ganhou, perdeu, db_timeout, db_estado, db_rodada, db_endereco);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks (inputs change on the falling edge).
    task automatic load(input logic [AWB-1:0] a, input logic [NB-1:0] d);
        @(negedge clock);
        carga_we = 1'b1; carga_end = a; carga_dado = d;
        @(negedge clock);
        carga_we = 1'b0;
    endtask

    task automatic start_game(input logic m);
        @(negedge clock);
        modo = m; jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
    endtask

    task automatic press(input logic [NB-1:0] v);
        @(negedge clock);
        botoes = v;
        repeat (3) @(negedge clock);
        botoes = '0;
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_state(input string tag, input logic [3:0] st, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (db_estado == st) break;
            @(negedge clock);
        end
        check(tag, 32'(db_estado), 32'(st));
    endtask

    // Scoreboard: pop the expected final outcome once the game reports pronto.
    task automatic wait_final(input string tag, input int budget);
        logic [11:0] e;
        for (int n = 0; n < budget; n++) begin
            if (pronto) break;
            @(negedge clock);
        end
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(observed()), 32'(e));
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; jogar = 1'b0; modo = 1'b0; botoes = '0;
        carga_we = 1'b0; carga_end = '0; carga_dado = '0;
        repeat (3) @(negedge clock);

        // Reset state.
        check("reset_status", 32'(observed()), 32'(pack(0, 0, 0, 0, S_INICIAL, 0, 0)));
        check("reset_leds", 32'(leds), 32'd0);
        reset = 1'b1;

        load(0, 4'b0001); load(1, 4'b0010); load(2, 4'b0100); load(3, 4'b1000);

        // Win in replay mode; a jogar pulse mid-game must be ignored.
        exp_q.push_back(pack(1, 1, 0, 0, S_GANHOU, 3, 3));
        start_game(1'b0);
        press(4'b0001);
        start_game(1'b0);
        check("jogar_ignored_rodada", 32'(db_rodada), 32'd1);
        press(4'b0001); press(4'b0010);
        press(4'b0001); press(4'b0010); press(4'b0100);
        press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
        wait_final("win", 20);

        // Wrong second press in round 1.
        exp_q.push_back(pack(1, 0, 1, 0, S_ERRO, 1, 1));
        start_game(1'b0);
        press(4'b0001);
        press(4'b0001); press(4'b0100);
        wait_final("wrong_press", 20);

        // Timeout after exactly TMO cycles in ESPERA.
        exp_q.push_back(pack(1, 0, 1, 1, S_TMO, 0, 0));
        start_game(1'b0);
        wait_state("enter_espera", S_ESPERA, 5);
        n = 0;
        while (!pronto && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TMO));
        wait_final("timeout", 5);

        // A press on cycle 9 beats the timeout; the next round then times out.
        exp_q.push_back(pack(1, 0, 1, 1, S_TMO, 1, 0));
        start_game(1'b0);
        wait_state("enter_espera2", S_ESPERA, 5);
        repeat (7) @(negedge clock);
        botoes = 4'b0001;
        @(negedge clock);
        @(negedge clock);
        check("late_press_registra", 32'(db_estado), 32'(S_REGIS));
        @(negedge clock);
        botoes = '0;
        wait_final("late_press_then_timeout", 40);

        // Non-one-hot press: leds show it only in REGISTRA/COMPARA.
        exp_q.push_back(pack(1, 0, 1, 0, S_ERRO, 0, 0));
        start_game(1'b0);
        botoes = 4'b0011;
        @(negedge clock);
        check("invalid_leds_espera", 32'(leds), 32'd0);
        @(negedge clock);
        check("invalid_leds_registra", 32'(leds), 32'h3);
        @(negedge clock);
        check("invalid_st_compara", 32'(db_estado), 32'(S_COMPARA));
        check("invalid_leds_compara", 32'(leds), 32'h3);
        @(negedge clock);
        check("invalid_leds_final", 32'(leds), 32'd0);
        botoes = '0;
        wait_final("invalid", 5);

        // Append mode: mem becomes {1,8,2,..}; replaying 1,2 then fails at address 1.
        exp_q.push_back(pack(1, 0, 1, 0, S_ERRO, 2, 1));
        start_game(1'b1);
        press(4'b0001); press(4'b1000);
        press(4'b0001); press(4'b1000); press(4'b0010);
        check("append_rodada", 32'(db_rodada), 32'd2);
        press(4'b0001); press(4'b0010);
        wait_final("append", 20);

        // Reset in PROX_JOGADA returns to INICIAL with all outputs low.
        modo = 1'b0;
        start_game(1'b0);
        press(4'b0001);
        @(negedge clock);
        botoes = 4'b0001;
        wait_state("reach_prox_jogada", S_PROXJ, 10);
        reset = 1'b0; botoes = '0;
        @(negedge clock);
        check("midgame_reset_status", 32'(observed()), 32'(pack(0, 0, 0, 0, S_INICIAL, 0, 0)));
        check("midgame_reset_leds", 32'(leds), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Replay with memory {1,8,2,8}; a preload attempted in ESPERA is dropped.
        exp_q.push_back(pack(1, 1, 0, 0, S_GANHOU, 3, 3));
        start_game(1'b0);
        @(negedge clock);
        carga_we = 1'b1; carga_end = 2'd0; carga_dado = 4'b0100;
        @(negedge clock);
        carga_we = 1'b0;
        press(4'b0001);
        press(4'b0001); press(4'b1000);
        press(4'b0001); press(4'b1000); press(4'b0010);
        press(4'b0001); press(4'b1000); press(4'b0010); press(4'b1000);
        wait_final("replay_after_reset", 20);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jogo_sequencias_param.md
Name: jogo_sequencias_param

Overview:
Parametrised single-module successor to the exp5 memory-sequence game (datapath plus control unit). The player repeats a stored sequence of button presses, one round longer each time. Generalised in button count, sequence depth and timeout. Adds a mode in which the player extends the sequence with a new press each round. Sits at the top of the game datapath, below the FPGA board wrapper that drives the displays.

Parameters:
N_BOTOES, 4, number of buttons/LEDs; the jogada width.
PROF, 16, maximum sequence depth (rounds); must be at least 2.
AW, $clog2(PROF), address width for the sequence memory and counters.
TIMEOUT_CICLOS, 5000, clock cycles allowed in ESPERA before timeout.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low; 0 on a clock edge forces INICIAL.
jogar  in  1  start/restart level; acted on at its rising edge (internally registered).
modo  in  1  sampled when leaving INICIAL/final states; 0 = replay preloaded sequence, 1 = player appends a new jogada each round.
botoes  in  N_BOTOES  raw button levels, active-high.
carga_we  in  1  sequence-memory write enable; honoured only in INICIAL or a final state.
carga_end  in  AW  preload address.
carga_dado  in  N_BOTOES  preload data (one-hot expected, not checked).
leds  out  N_BOTOES  last registered jogada during REGISTRA..PROX_RODADA, else 0.
pronto  out  1  high in any final state.
ganhou  out  1  high only in FIM_GANHOU.
perdeu  out  1  high in FIM_ERRO or FIM_TIMEOUT.
db_timeout  out  1  high only in FIM_TIMEOUT.
db_estado  out  4  state code.
db_rodada  out  AW  current round (limit counter).
db_endereco  out  AW  current address counter.

Behaviour:
- Reset (reset=0 at edge):
  - state INICIAL; rodada, endereco and the timeout counter cleared.
  - all outputs 0.
  - memory contents preserved; reset mid-game is identical to power-up except for memory.
- Button input: botoes registered once (b_q), then once more (b_qq). tem_jogada = (b_q!=0) && (b_qq==0).
  - Jogada invalid if b_q is not one-hot. An invalid jogada compares as a mismatch.
- States (db_estado codes):
  - INICIAL(0): on jogar rising edge -> PREPARA.
  - PREPARA(1): clear rodada, endereco and timeout counter; latch modo -> ESPERA.
  - ESPERA(2): timeout counter increments each cycle.
    - tem_jogada -> REGISTRA.
    - counter == TIMEOUT_CICLOS-1 with no jogada -> FIM_TIMEOUT.
    - tem_jogada wins if both occur in the same cycle.
  - REGISTRA(3): jogada <= b_q; timeout counter cleared -> COMPARA.
  - COMPARA(4):
    - mismatch or invalid -> FIM_ERRO.
    - match and endereco<rodada -> PROX_JOGADA.
    - match and endereco==rodada: rodada==PROF-1 -> FIM_GANHOU; else modo=0 -> PROX_RODADA; modo=1 -> ESPERA_NOVA.
  - PROX_JOGADA(5): endereco++ -> ESPERA.
  - PROX_RODADA(6): rodada++, endereco=0, timeout cleared -> ESPERA.
  - ESPERA_NOVA(7): same timeout rule as ESPERA.
    - tem_jogada with valid one-hot -> ESCREVE.
    - invalid -> FIM_ERRO.
  - ESCREVE(8): mem[rodada+1] <= b_q -> PROX_RODADA.
  - FIM_GANHOU(0xA), FIM_ERRO(0xE), FIM_TIMEOUT(0xD): outputs held; carga accepted; jogar rising edge -> PREPARA.
- Latency: tem_jogada seen in ESPERA -> COMPARA two cycles later -> final state on the third cycle.
- Counters never wrap: rodada stops at PROF-1, endereco never exceeds rodada.
- A jogar rising edge during active play is ignored.
- Memory: PROF x N_BOTOES, synchronous write, asynchronous read at endereco.
  - A carga write while not accepted is dropped silently.

Decomposition:
- Package jogo_pkg: state encodings (4-bit localparams above) and a one-hot check function.
- One sub-module, detector_jogada: 2-stage register, edge detect, validity flag.
- Counters, memory and FSM stay in the top module.

Test Plan:
- Bench parameters: N_BOTOES=4, PROF=4, TIMEOUT_CICLOS=10.
- Preload mem = {1,2,4,8}, modo=0, correct presses for rounds 0..3 -> FIM_GANHOU, ganhou=1, pronto=1, db_estado=0xA, db_rodada=3.
- Same preload, round 1 second press 4'b0100 instead of 2 -> FIM_ERRO, perdeu=1, db_endereco=1, db_rodada=1.
- Enter ESPERA with no press for 10 cycles -> FIM_TIMEOUT, perdeu=1, db_timeout=1. A press on cycle 9 -> no timeout.
- Press 4'b0011 in ESPERA -> FIM_ERRO; leds=0011 during REGISTRA/COMPARA only.
- modo=1, mem[0]=1: play 1 then new 8 -> mem[1]=8; play 1,8 then new 2 -> mem[2]=2; then play 1,2 -> FIM_ERRO at endereco 1.
- reset=0 in PROX_JOGADA -> INICIAL next edge, all outputs 0; jogar replay uses unchanged memory; carga_we during ESPERA has no effect.
